// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply unit and the control unit's stall logic.
package mult_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_LATENCY = MULT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

endpackage

// File: rtl/hilo_mult.sv
// Iterative radix-2 shift-add multiplier that owns the HI/LO register pair.
// Define HILO_MULT_SIGNED_EN to honour is_signed (mult); otherwise every request is multu.
module hilo_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplr_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic                 neg_d;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_d;

`ifdef HILO_MULT_SIGNED_EN
  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exactly right unsigned.
  always_comb begin
    mag_a_d = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_d = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  assign prod_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
`else
  logic unused_sign_bits;
  assign unused_sign_bits = is_signed | neg_q;

  always_comb begin
    mag_a_d = a;
    mag_b_d = b;
    neg_d   = 1'b0;
  end

  assign prod_d = acc_q;
`endif

  // The extra top bit holds the carry so the shift brings it into the product.
  assign sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d = {sum_d, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= mag_a_d;
            mplr_q  <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          {hi_q, lo_q} <= prod_d;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mult.sv
// Directed self-checking bench for hilo_mult; signed cases follow HILO_MULT_SIGNED_EN.
module tb_hilo_mult;
  import mult_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total;
  int          bad;
  logic [63:0] lastProd;

  hilo_mult #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle start; returns just after the edge that samples it.
  task automatic applyStimulus(input logic [31:0] aV, input logic [31:0] bV, input logic sV);
    @(posedge clk); #1;
    a = aV;
    b = bV;
    is_signed = sV;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walks cycles after the start edge until done; optionally injects a second start.
  task automatic watchRun(input int injectAt, input logic [31:0] ia, input logic [31:0] ib,
                          output int busyCnt, output int doneAt,
                          output logic [63:0] prod, output logic [63:0] midProd);
    busyCnt = 0;
    doneAt  = -1;
    prod    = '0;
    midProd = '0;
    for (int i = 0; i <= 60; i++) begin
      if (i == injectAt) begin
        a = ia;
        b = ib;
        start = 1'b1;
      end
      if (i == injectAt + 1) start = 1'b0;
      if (i == 10) midProd = {hi, lo};
      if (busy) busyCnt++;
      if (done) begin
        doneAt = i;
        prod = {hi, lo};
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic runMult(input string tag, input logic [31:0] aV, input logic [31:0] bV,
                         input logic sV, input logic [63:0] expP);
    int busyCnt;
    int doneAt;
    logic [63:0] prod;
    logic [63:0] midProd;
    applyStimulus(aV, bV, sV);
    watchRun(-1, '0, '0, busyCnt, doneAt, prod, midProd);
    checkOutput({tag, "_busy"}, 64'(busyCnt), 64'd33);
    checkOutput({tag, "_lat"}, 64'(doneAt), 64'(MULT_LATENCY));
    checkOutput({tag, "_hold"}, midProd, lastProd);
    checkOutput({tag, "_prod"}, prod, expP);
    lastProd = expP;
    @(posedge clk); #1;
    checkOutput({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int busyCnt;
    int doneAt;
    int doneSeen;
    logic [63:0] prod;
    logic [63:0] midProd;

    total = 0;
    bad = 0;
    lastProd = '0;
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    runMult("u4x2", 32'd4, 32'd2, 1'b0, 64'd8);
    runMult("uFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    runMult("uFCx3", 32'hFFFF_FFFC, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFF4);
`ifdef HILO_MULT_SIGNED_EN
    runMult("sM4x3", 32'hFFFF_FFFC, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
    runMult("s3xM4", 32'd3, 32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
`else
    runMult("sM4x3", 32'hFFFF_FFFC, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFF4);
`endif
    runMult("s80x80", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

    // Second start at k+10 must be dropped; start held in the done cycle must launch.
    applyStimulus(32'd5, 32'd5, 1'b0);
    watchRun(9, 32'd7, 32'd7, busyCnt, doneAt, prod, midProd);
    checkOutput("ign_lat", 64'(doneAt), 64'd33);
    checkOutput("ign_hold", midProd, lastProd);
    checkOutput("ign_prod", prod, 64'd25);
    lastProd = 64'd25;
    a = 32'd6;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    watchRun(-1, '0, '0, busyCnt, doneAt, prod, midProd);
    checkOutput("b2b_cnt", 64'(busyCnt), 64'd33);
    checkOutput("b2b_lat", 64'(doneAt), 64'd33);
    checkOutput("b2b_prod", prod, 64'd18);
    lastProd = 64'd18;

    // Reset at k+10 aborts the run and clears HI/LO.
    applyStimulus(32'd4, 32'd2, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    lastProd = '0;
    doneSeen = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) doneSeen++;
      @(posedge clk); #1;
    end
    checkOutput("abort_nodone", 64'(doneSeen), 64'd0);
    runMult("u6x7", 32'd6, 32'd7, 1'b0, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_mult.md
# hilo_mult

Iterative multiply unit that executes the processor's `mult`/`multu` instructions and owns the HI/LO register pair that `mflo`/`mfhi` read. The datapath issues `start` with the two `rs`/`rt` operands. The block runs a radix-2 shift-add sequence, raises `busy` while the sequence runs, and writes the 2*WIDTH-bit product into HI/LO. The control unit stalls the fetch of any `mfhi`/`mflo` while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width; the product is 2*WIDTH bits.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: launches a multiply; honoured only in IDLE.
- `is_signed`  in  1: 1 = `mult` (two's complement), 0 = `multu`; sampled with `start`.
- `a`  in  WIDTH: multiplicand (`rs`); sampled with `start`.
- `b`  in  WIDTH: multiplier (`rt`); sampled with `start`.
- `busy`  out  1: high while state is RUN or FIN.
- `done`  out  1: one-cycle pulse when HI/LO have just been updated.
- `hi`  out  WIDTH: upper half of the last completed product.
- `lo`  out  WIDTH: lower half of the last completed product.

## Operation
- States: IDLE, RUN, FIN.
- IDLE to RUN on `start`:
  - Latches |a| and |b|. Absolute value is taken only if `is_signed` is set and the operand MSB is 1.
  - Latches `neg = is_signed & (a[MSB] ^ b[MSB])`.
  - Clears the 2*WIDTH accumulator and loads `cnt = WIDTH`.
- RUN, each cycle:
  - If multiplier bit 0 is 1, add the multiplicand into the accumulator's upper WIDTH+1 bits.
  - Shift the accumulator and the multiplier right by 1.
  - Decrement `cnt`.
  - Go to FIN after the cycle in which `cnt` goes from 1 to 0.
- FIN:
  - Write `{hi,lo}` with the accumulator, two's-complement negated over 2*WIDTH bits if `neg`.
  - Pulse `done`. Return to IDLE.
- Arithmetic:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as an unsigned WIDTH-bit value. No overflow case exists.
  - The addition carry is kept in a WIDTH+1-bit adder.
- `start` in RUN or FIN is ignored. No queueing; the operands are discarded.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.
- HI/LO change only in FIN. They hold their value through the whole next multiply until its FIN.

## Timing
- Reset values: `busy=0`, `done=0`, `hi=0`, `lo=0`, state IDLE, `cnt=0`.
- Reset mid-operation aborts the sequence, clears HI/LO, and produces no `done`.
- `start` is sampled at edge k. `busy` is high from after edge k until after edge k+WIDTH+1.
- `done`, `hi` and `lo` are valid after edge k+WIDTH+1 (33 cycles for WIDTH=32). `busy` is 0 in the `done` cycle.
- Back-to-back throughput: one product every WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `HILO_MULT_SIGNED_EN` defined:
  - `is_signed` is honoured.
  - The absolute-value and negate logic is built.
- Undefined:
  - `is_signed` is ignored, and `mult` behaves as `multu`.
  - `neg` is a constant 0 and the negation logic is removed.
  - Port list unchanged.

## Structure
- Shared package `mult_pkg` holds:
  - The state enum (IDLE, RUN, FIN).
  - The `MULT_WIDTH=32` constant used as the default for `WIDTH`.
  - A `MULT_LATENCY = MULT_WIDTH+1` constant for the control unit's stall logic.
- Single module. No sub-module is warranted: the absolute-value and negate steps are one adder each, written inline.

## Test plan
- Unsigned `a=4`, `b=2`, `start` at edge k: `busy` high for 33 cycles, then `done` with `hi=0`, `lo=8`.
- Unsigned `a=b=0xFFFFFFFF`: `hi=0xFFFFFFFE`, `lo=0x00000001`.
- Signed `a=0xFFFFFFFC` (-4), `b=3`: `hi=0xFFFFFFFF`, `lo=0xFFFFFFF4`. Signed `a=b=0x80000000`: `hi=0x40000000`, `lo=0`. Both cases only with the macro defined. Without the macro, the first case gives `hi=0x00000002`, `lo=0xFFFFFFF4`.
- `start` with `a=5`, `b=5`, then `start` again with `a=7`, `b=7` at k+10: second request ignored; `done` at k+33 with `lo=25`. A `start` held high during the `done` cycle launches the next multiply.
- Reset at k+10 during `a=4`, `b=2`: the next cycle shows `busy=0`, `hi=lo=0`, and `done` never pulses. A fresh `a=6`, `b=7` then yields `lo=42`.
